// File: rtl/instr_encoder_if.sv
// Host-to-encoder instruction handshake and encoder-to-RAM write port.
// The encoder is the slave: it consumes descriptions and drives the RAM strobe.
interface instr_encoder_if #(
  parameter int ADDR_W = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_op;
  logic [3:0]        in_cond;
  logic [2:0]        in_ra;
  logic [2:0]        in_rb;
  logic [2:0]        in_rc;
  logic [15:0]       in_imm;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;

  modport master (
    output in_valid, in_fmt, in_op, in_cond, in_ra, in_rb, in_rc, in_imm,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_fmt, in_op, in_cond, in_ra, in_rb, in_rc, in_imm,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded instruction descriptions into 16-bit CPU words and writes them
// to instruction RAM at an auto-incrementing pointer, with trailing immediates.
module instr_encoder #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  instr_encoder_if.slave    bus,
  output logic              err,
  output logic              full,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic {IDLE, IMM} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              err_q, err_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic [15:0]       imm_q, imm_d;

  logic        accept;
  logic        legal;
  logic        two_word;
  logic        last;
  logic        do_wr;
  logic [15:0] enc_word;
  logic [15:0] wr_word;

  assign bus.in_ready = (state_q == IDLE) & ~start & ~full_q;
  assign accept       = bus.in_valid & bus.in_ready;
  assign last         = &ptr_q;
  assign two_word     = (bus.in_fmt == 3'd0) &&
                        (bus.in_op >= 7'd10) && (bus.in_op <= 7'd12);

  // Word packing and legality for each format class.
  always_comb begin
    enc_word = 16'h0000;
    legal    = 1'b0;
    case (bus.in_fmt)
      3'd0: begin
        enc_word = {2'b00, bus.in_op, bus.in_cond, bus.in_ra};
        legal    = bus.in_op <= 7'd12;
      end
      3'd1: begin
        enc_word = {3'b001, bus.in_op[1:0], bus.in_cond, bus.in_ra, bus.in_imm[3:0]};
        legal    = bus.in_op <= 7'd3;
      end
      3'd2: begin
        enc_word = {2'b01, bus.in_op[3:0], bus.in_cond, bus.in_ra, bus.in_rb};
        legal    = bus.in_op <= 7'd15;
      end
      3'd3: begin
        enc_word = {2'b10, bus.in_op[0], bus.in_cond, bus.in_ra, bus.in_rb, bus.in_rc};
        legal    = bus.in_op <= 7'd1;
      end
      3'd4: begin
        enc_word = {2'b11, bus.in_op[1:0], bus.in_imm[11:0]};
        legal    = bus.in_op <= 7'd2;
      end
      3'd5: begin
        enc_word = {5'b11110, bus.in_op, bus.in_cond};
        legal    = bus.in_op <= 7'd16;
      end
      3'd6: begin
        enc_word = {5'b11111, bus.in_op[3:0], bus.in_cond, bus.in_imm[2:0]};
        legal    = bus.in_op <= 7'd1;
      end
      default: begin
        enc_word = 16'h0000;
        legal    = 1'b0;
      end
    endcase
    // Condition 1110 is reserved everywhere except the direct format, which has no cond field.
    if (bus.in_fmt != 3'd4 && bus.in_cond == 4'b1110) legal = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    full_d    = full_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    imm_d     = imm_q;
    do_wr     = 1'b0;
    wr_word   = imm_q;

    if (start) begin
      state_d = IDLE;
      ptr_d   = start_addr;
      cnt_d   = '0;
      full_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            // A two-word instruction needs two free slots or it is dropped whole.
            if (!legal || (two_word && last)) begin
              err_d = 1'b1;
            end else begin
              do_wr   = 1'b1;
              wr_word = enc_word;
              if (two_word) begin
                state_d = IMM;
                imm_d   = bus.in_imm;
              end
            end
          end
        end
        IMM: begin
          do_wr   = 1'b1;
          wr_word = imm_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    if (do_wr) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ptr_q;
      wr_data_d = wr_word;
      ptr_d     = ptr_q + 1'b1;
      cnt_d     = cnt_q + 1'b1;
      if (last) full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // The latched immediate is only consumed from IMM, so it needs no reset.
  always_ff @(posedge clk) begin
    imm_q <= imm_d;
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign err         = err_q;
  assign full        = full_q;
  assign word_count  = cnt_q;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential instruction encoder and program writer for the 16-bit CPU. It accepts one decoded instruction description per handshake (format class, opcode index, condition, register and immediate fields). It packs these into the exact 16-bit word layout the CPU's instruction decoder consumes and writes the result into instruction RAM at an auto-incrementing address. It sits between the host/boot loader and the instruction RAM write port, and also emits the trailing immediate word for three-cycle instructions (LDI/AIM/SIM).

## Interface
- ADDR_W, 12, instruction RAM address width (matches the 12-bit direct-address field)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  load `start_addr` into the write pointer; clear `full` and `err`
- start_addr  in  ADDR_W  first RAM address for the following program
- in_valid  in  1  instruction description present
- in_ready  out  1  encoder accepts on `in_valid & in_ready`
- in_fmt  in  3  0 single_reg, 1 single_reg_ba, 2 double_reg, 3 triple_reg, 4 direct, 5 control, 6 control_offset, 7 illegal
- in_op  in  7  opcode index within format
- in_cond  in  4  condition field (0110 = always)
- in_ra / in_rb / in_rc  in  3 each  register fields
- in_imm  in  16  bit index / address / offset / immediate word
- wr_en  out  1  RAM write strobe
- wr_addr  out  ADDR_W  RAM write address
- wr_data  out  16  encoded word
- err  out  1  sticky: illegal description or overflow rejected
- full  out  1  write pointer has passed the last address
- word_count  out  ADDR_W+1  words written since last `start`/reset

## Operation
- Field layouts (bit ranges of wr_data):
  - fmt0: [15:7]=op, [6:3]=cond, [2:0]=ra; legal op 0..12.
  - fmt1: [15:13]=001, [12:11]=op, [10:7]=cond, [6:4]=ra, [3:0]=imm[3:0]; legal op 0..3.
  - fmt2: [15:14]=01, [13:10]=op, [9:6]=cond, [5:3]=ra, [2:0]=rb; all 16 ops legal.
  - fmt3: [15:13]=10,op[0], [12:9]=cond, [8:6]=ra, [5:3]=rb, [2:0]=rc; legal op 0..1.
  - fmt4: [15:14]=11, [13:12]=op, [11:0]=imm[11:0]; legal op 0..2; cond ignored.
  - fmt5: [15:11]=11110, [10:4]=op, [3:0]=cond; legal op 0..16.
  - fmt6: [15:11]=11111, [10:7]=op[3:0], [6:3]=cond, [2:0]=imm[2:0]; legal op 0..1.
- Illegal: fmt 7, op outside legal range, or cond = 1110 (except fmt4). Such a description is accepted (consumed), nothing is written, and `err` is set.
- Two-word: fmt0 op 10/11/12 write the instruction word, then `in_imm` at the next address.
- FSM states:
  - IDLE: `in_ready` = ~start & ~full. A legal accept writes word 0; a two-word instruction goes to IMM, otherwise stays in IDLE.
  - IMM: `in_ready`=0; writes the latched immediate, then returns to IDLE.
- Write pointer increments per word written. `full` sets when a write lands on address 2^ADDR_W−1; the pointer wraps to 0 but no further accepts occur.
- If a two-word instruction is accepted with exactly one free slot (pointer = 2^ADDR_W−1), it is rejected whole: no write, `err`=1.
- `start` overrides `in_valid` in the same cycle. `start` during IMM abandons the pending immediate; the pointer is reloaded.

## Timing
- Reset values: state IDLE, wr_en=0, wr_addr=0, wr_data=0, err=0, full=0, word_count=0, pointer=0. `in_ready`=1 after reset.
- wr_en/wr_addr/wr_data are registered: a word accepted at edge N appears during cycle N+1, as a single-cycle strobe.
- Two-word instruction: words at cycles N+1 and N+2; `in_ready` low during cycle N+1; next accept is at edge N+2 at the earliest.
- Single-word throughput: one instruction per cycle.
- `err`/`full` update on the edge after the triggering accept; cleared on the edge that samples `start`.
- Reset asserted mid-IMM: pending immediate is discarded and all outputs go immediately to reset values.

## Test plan
- start_addr=0x010, then fmt2 op0 cond0110 ra=3 rb=5 -> wr_addr 0x010, wr_data 0x419D, word_count 1.
- fmt0 op10 cond0110 ra=2 imm 0xBEEF at ptr 0x020 -> 0x0532@0x020, then 0xBEEF@0x021, in_ready low one cycle, next accept lands at 0x022.
- Back-to-back: fmt4 op1 imm 0x123 -> 0xD123; fmt5 op1 cond0110 -> 0xF016; fmt6 op0 cond0110 imm5 -> 0xF835; fmt1 op0 ra=4 imm9 -> 0x2349; fmt3 op0 ra=1 rb=2 rc=3 -> 0x8C53; five consecutive strobes.
- Illegal inputs: fmt7; fmt0 op13; fmt2 cond1110 -> no wr_en, err=1 sticky; start clears err.
- start_addr=0xFFF: single-word instruction -> write @0xFFF, full=1, in_ready=0; with start_addr=0xFFF, an LDI instead -> no write, err=1.
- Reset asserted in IMM cycle -> no immediate written, wr_en=0 immediately, word_count=0.
